// File: rtl/synth_ctrl_regs_if.sv
// Avalon-MM slave bus bundle for the synth control register block.
interface synth_ctrl_regs_if;
    logic [6:0]  AVL_ADDR;
    logic [3:0]  AVL_BYTE_EN;
    logic        AVL_READ;
    logic        AVL_WRITE;
    logic        AVL_CS;
    logic [31:0] AVL_WRITEDATA;
    logic [31:0] AVL_READDATA;
    logic        AVL_READDATAVALID;

    modport master (
        output AVL_ADDR, AVL_BYTE_EN, AVL_READ, AVL_WRITE, AVL_CS, AVL_WRITEDATA,
        input  AVL_READDATA, AVL_READDATAVALID
    );

    modport slave (
        input  AVL_ADDR, AVL_BYTE_EN, AVL_READ, AVL_WRITE, AVL_CS, AVL_WRITEDATA,
        output AVL_READDATA, AVL_READDATAVALID
    );
endinterface

// File: rtl/synth_ctrl_regs.sv
// Synth engine control slave: immediate global registers, double-buffered
// per-voice FREQ/AMP banks applied on SAMPLE_TICK after COMMIT, and a key
// event FIFO drained by the voice allocator.
module synth_ctrl_regs #(
    parameter int NUM_VOICES = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int AMP_W      = 16
) (
    input  logic                        CLK,
    input  logic                        RESET,
    synth_ctrl_regs_if.slave            avl,
    input  logic                        SAMPLE_TICK,
    output logic [1:0]                  SHAPE0,
    output logic [1:0]                  SHAPE1,
    output logic [15:0]                 ATTACK,
    output logic [15:0]                 DECAY,
    output logic [15:0]                 SUSTAIN,
    output logic [15:0]                 RLEASE,
    output logic                        GLIDE_EN,
    output logic                        ARP_EN,
    output logic [15:0]                 GLIDE_RATE,
    output logic [15:0]                 ARP_TIME,
    output logic [7*NUM_VOICES-1:0]     FREQ,
    output logic [AMP_W*NUM_VOICES-1:0] AMP0,
    output logic [AMP_W*NUM_VOICES-1:0] AMP1,
    output logic                        EVT_VALID,
    output logic [15:0]                 EVT_DATA,
    input  logic                        EVT_POP,
    output logic                        COMMIT_PENDING
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic        wr;
    logic        rd;
    logic [31:0] wmask;
    logic [31:0] rd_mux;
    logic [3:0]  voice;

    logic [3:0]  shape;
    logic [1:0]  ctrl;
    logic        commit_pending;
    logic        commit_wr;
    logic        apply;

    logic [6:0]       freq_sh  [NUM_VOICES];
    logic [AMP_W-1:0] amp0_sh  [NUM_VOICES];
    logic [AMP_W-1:0] amp1_sh  [NUM_VOICES];
    logic [6:0]       freq_act [NUM_VOICES];
    logic [AMP_W-1:0] amp0_act [NUM_VOICES];
    logic [AMP_W-1:0] amp1_act [NUM_VOICES];

    logic [15:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             push_req;
    logic             do_push;
    logic             do_pop;

    assign wr        = avl.AVL_WRITE & avl.AVL_CS;
    assign rd        = avl.AVL_READ & avl.AVL_CS;
    assign voice     = avl.AVL_ADDR[3:0];
    assign commit_wr = wr && (avl.AVL_ADDR == 7'd8);
    assign apply     = SAMPLE_TICK && commit_pending;

    assign full      = (level == LVL_W'(FIFO_DEPTH));
    assign empty     = (level == '0);
    assign push_req  = wr && (avl.AVL_ADDR == 7'd10);
    assign do_pop    = EVT_POP && !empty;
    assign do_push   = push_req && (!full || do_pop);

    // Byte-lane write mask and merge: unselected lanes keep the current value.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < 4; i++) begin
            wmask[8*i +: 8] = {8{avl.AVL_BYTE_EN[i]}};
        end
    end

    function automatic logic [31:0] merge_be(input logic [31:0] cur);
        return (cur & ~wmask) | (avl.AVL_WRITEDATA & wmask);
    endfunction

    // Read mux: current (pre-write) value of the addressed register, zero-extended.
    always_comb begin
        rd_mux = '0;
        case (avl.AVL_ADDR)
            7'd0: rd_mux = {28'd0, shape};
            7'd1: rd_mux = {16'd0, ATTACK};
            7'd2: rd_mux = {16'd0, DECAY};
            7'd3: rd_mux = {16'd0, SUSTAIN};
            7'd4: rd_mux = {16'd0, RLEASE};
            7'd5: rd_mux = {30'd0, ctrl};
            7'd6: rd_mux = {16'd0, GLIDE_RATE};
            7'd7: rd_mux = {16'd0, ARP_TIME};
            7'd9: rd_mux = {16'd0, 8'(level), 4'd0, overflow, empty, full, commit_pending};
            default: begin
                if (avl.AVL_ADDR[6]) begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (voice == 4'(v)) begin
                            case (avl.AVL_ADDR[5:4])
                                2'd0:    rd_mux = 32'(freq_sh[v]);
                                2'd1:    rd_mux = 32'(amp1_sh[v]);
                                2'd2:    rd_mux = 32'(amp0_sh[v]);
                                default: rd_mux = '0;
                            endcase
                        end
                    end
                end
            end
        endcase
    end

    // Immediate-effect global registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            shape      <= '0;
            ATTACK     <= '0;
            DECAY      <= '0;
            SUSTAIN    <= '0;
            RLEASE     <= '0;
            ctrl       <= '0;
            GLIDE_RATE <= '0;
            ARP_TIME   <= '0;
        end else if (wr) begin
            case (avl.AVL_ADDR)
                7'd0: shape      <= 4'(merge_be(rd_mux));
                7'd1: ATTACK     <= 16'(merge_be(rd_mux));
                7'd2: DECAY      <= 16'(merge_be(rd_mux));
                7'd3: SUSTAIN    <= 16'(merge_be(rd_mux));
                7'd4: RLEASE     <= 16'(merge_be(rd_mux));
                7'd5: ctrl       <= 2'(merge_be(rd_mux));
                7'd6: GLIDE_RATE <= 16'(merge_be(rd_mux));
                7'd7: ARP_TIME   <= 16'(merge_be(rd_mux));
                default: ;
            endcase
        end
    end

    assign SHAPE0   = shape[1:0];
    assign SHAPE1   = shape[3:2];
    assign GLIDE_EN = ctrl[0];
    assign ARP_EN   = ctrl[1];

    // Shadow bank: written by the bus, voices beyond NUM_VOICES never match.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                freq_sh[v] <= '0;
                amp0_sh[v] <= '0;
                amp1_sh[v] <= '0;
            end
        end else if (wr && avl.AVL_ADDR[6]) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (voice == 4'(v)) begin
                    case (avl.AVL_ADDR[5:4])
                        2'd0:    freq_sh[v] <= 7'(merge_be(rd_mux));
                        2'd1:    amp1_sh[v] <= AMP_W'(merge_be(rd_mux));
                        2'd2:    amp0_sh[v] <= AMP_W'(merge_be(rd_mux));
                        default: ;
                    endcase
                end
            end
        end
    end

    // Active bank: atomic copy of the pre-write shadow values on apply.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                freq_act[v] <= '0;
                amp0_act[v] <= '0;
                amp1_act[v] <= '0;
            end
        end else if (apply) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                freq_act[v] <= freq_sh[v];
                amp0_act[v] <= amp0_sh[v];
                amp1_act[v] <= amp1_sh[v];
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice_out
        assign FREQ[7*v +: 7]     = freq_act[v];
        assign AMP0[AMP_W*v +: AMP_W] = amp0_act[v];
        assign AMP1[AMP_W*v +: AMP_W] = amp1_act[v];
    end

    // Commit flag: a COMMIT write wins over the clear so a coincident tick defers to the next one.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            commit_pending <= 1'b0;
        end else if (commit_wr) begin
            commit_pending <= 1'b1;
        end else if (apply) begin
            commit_pending <= 1'b0;
        end
    end

    assign COMMIT_PENDING = commit_pending;

    // Event FIFO storage, pointers, level and sticky overflow.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                fifo_mem[wr_ptr] <= avl.AVL_WRITEDATA[15:0];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
            if (push_req && full && !do_pop) begin
                overflow <= 1'b1;
            end else if (wr && (avl.AVL_ADDR == 7'd9) && avl.AVL_BYTE_EN[0] && avl.AVL_WRITEDATA[3]) begin
                overflow <= 1'b0;
            end
        end
    end

    assign EVT_VALID = !empty;
    assign EVT_DATA  = empty ? 16'h0000 : fifo_mem[rd_ptr];

    // Registered read port: data is zero except in the single valid cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            avl.AVL_READDATA      <= '0;
            avl.AVL_READDATAVALID <= 1'b0;
        end else begin
            avl.AVL_READDATA      <= rd ? rd_mux : 32'd0;
            avl.AVL_READDATAVALID <= rd;
        end
    end

endmodule
